// File: rtl/stim_pkg.sv
// Shared types and helpers for the stimulus vector generator.
package stim_pkg;

  localparam int unsigned LFSR_MAX_W = 32;

  typedef enum logic [1:0] {
    CONST = 2'd0,
    INCR  = 2'd1,
    LFSR  = 2'd2,
    WALK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Galois step on a zero-extended value; callers truncate back to their width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] x,
                                                     input logic [LFSR_MAX_W-1:0] taps);
    return (x >> 1) ^ (x[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/stim_chan.sv
// One stimulus channel: seeding from the shared base seed and per-accept advance.
module stim_chan
  import stim_pkg::*;
#(
  parameter int unsigned           DATA_W    = 8,
  parameter logic [DATA_W-1:0]     LFSR_TAPS = 'hB8,
  parameter int unsigned           CH_IDX    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] value
);

  localparam int unsigned ROT = CH_IDX % DATA_W;

  logic [DATA_W-1:0] rotated;
  logic [DATA_W-1:0] walk_one;
  logic [DATA_W-1:0] seeded;
  logic [DATA_W-1:0] stepped;
  mode_e             mode_sel;

  assign mode_sel = mode_e'(mode);
  assign rotated  = (seed << ROT) | (seed >> (DATA_W - ROT));
  assign walk_one = DATA_W'(1) << ROT;

  // LFSR and WALK would lock up on an all-zero seed, so substitute a live value.
  always_comb begin
    seeded = rotated;
    if (rotated == '0) begin
      if (mode_sel == LFSR) seeded = DATA_W'(1);
      else if (mode_sel == WALK) seeded = walk_one;
    end
  end

  always_comb begin
    stepped = value;
    case (mode_sel)
      CONST:   stepped = value;
      INCR:    stepped = value + DATA_W'(1);
      LFSR:    stepped = DATA_W'(lfsr_step(LFSR_MAX_W'(value), LFSR_MAX_W'(LFSR_TAPS)));
      WALK:    stepped = {value[DATA_W-2:0], value[DATA_W-1]};
      default: stepped = value;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        value <= '0;
    else if (load)    value <= seeded;
    else if (advance) value <= stepped;
  end

endmodule

// File: rtl/stim_vector_gen.sv
// Multi-channel stimulus source with pattern modes and a valid/ready output.
module stim_vector_gen
  import stim_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       NUM_CH    = 2,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 'hB8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [DATA_W-1:0]        seed,
  input  logic [CNT_W-1:0]         num_vectors,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         vec_count
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q;
  logic [1:0]       mode_sel;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] vec_next;
  logic             load;
  logic             accept;

  assign vec_next = vec_count + CNT_W'(1);

  // stop outranks both start and an accept landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    accept    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          load    = 1'b1;
          state_d = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        accept    = out_ready && !stop;
        if (accept && vec_next == num_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      num_q     <= '0;
      vec_count <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mode_q    <= mode;
        num_q     <= num_vectors;
        vec_count <= '0;
      end else if (accept) begin
        vec_count <= vec_next;
      end
    end
  end

  // Channels seed from the live mode input since mode_q is written on the same edge.
  assign mode_sel = load ? mode : mode_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stim_chan #(
      .DATA_W   (DATA_W),
      .LFSR_TAPS(LFSR_TAPS),
      .CH_IDX   (g)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .advance(accept),
      .mode   (mode_sel),
      .seed   (seed),
      .value  (out_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_stim_vector_gen.sv
// Scoreboard bench for stim_vector_gen with DATA_W=8, NUM_CH=2.
module tb_stim_vector_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic [15:0] num_vectors;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic        done;
  logic [15:0] vec_count;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  stim_vector_gen #(
    .DATA_W   (8),
    .NUM_CH   (2),
    .CNT_W    (16),
    .LFSR_TAPS(8'hB8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .seed       (seed),
    .num_vectors(num_vectors),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .vec_count  (vec_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    int unsigned r;
    r = n % 8;
    return (x << r) | (x >> (8 - r));
  endfunction

  function automatic logic [7:0] seed_ch(input logic [1:0] m, input logic [7:0] s, input int unsigned i);
    logic [7:0] v;
    v = rotl8(s, i);
    if (v == 8'h00 && m == 2'd2) v = 8'h01;
    if (v == 8'h00 && m == 2'd3) v = 8'h01 << (i % 8);
    return v;
  endfunction

  function automatic logic [7:0] step_ch(input logic [1:0] m, input logic [7:0] x);
    case (m)
      2'd1:    return x + 8'h01;
      2'd2:    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
      2'd3:    return {x[6:0], x[7]};
      default: return x;
    endcase
  endfunction

  task automatic push_run(input logic [1:0] m, input logic [7:0] s, input int n);
    logic [7:0] c0, c1;
    c0 = seed_ch(m, s, 0);
    c1 = seed_ch(m, s, 1);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back({c1, c0});
      c0 = step_ch(m, c0);
      c1 = step_ch(m, c1);
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [7:0] s, input int n);
    @(posedge clk);
    #1;
    mode = m;
    seed = s;
    num_vectors = 16'(n);
    start = 1'b1;
    push_run(m, s, n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts negedges until done; checks latency, then that done lasts one cycle.
  task automatic wait_done(input string tag, input int exp_lat);
    int k;
    bit seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (done) seen = 1'b1;
    end
    if (seen) begin
      check({tag, "_lat"}, 32'(k), 32'(exp_lat));
      check({tag, "_valid_at_done"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, "_done_width"}, 32'(done), 32'd0);
    end else begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (done) done_cnt++;
    if (out_valid) valid_cnt++;
    if (!reset && out_valid && out_ready && !stop) begin
      if (exp_q.size() == 0) begin
        check("extra_vec", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("vec", 32'(out_data), 32'(e));
      end
    end
  end

  initial begin
    int v0, d0;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    mode = 2'd0;
    seed = 8'h00;
    num_vectors = 16'd0;
    out_ready = 1'b1;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(vec_count), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // INCR basic run
    start_run(2'd1, 8'h0C, 3);
    wait_done("incr", 4);
    check("incr_count", 32'(vec_count), 32'd3);
    repeat (2) @(negedge clk);
    check("incr_count_hold", 32'(vec_count), 32'd3);

    // INCR wrap
    start_run(2'd1, 8'hFF, 2);
    wait_done("wrap", 3);

    // LFSR, then LFSR from a zero seed
    start_run(2'd2, 8'h0C, 4);
    wait_done("lfsr", 5);
    start_run(2'd2, 8'h00, 1);
    wait_done("lfsr0", 2);

    // WALK with backpressure
    out_ready = 1'b0;
    start_run(2'd3, 8'h01, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", 32'(out_data), 32'h0201);
      check("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("walk_bp", 4);

    // zero-length run
    v0 = valid_cnt;
    start_run(2'd1, 8'h55, 0);
    wait_done("zero", 1);
    check("zero_valid", 32'(valid_cnt), 32'(v0));
    check("zero_count", 32'(vec_count), 32'd0);

    // start during RUN must not restart or reseed
    start_run(2'd1, 8'h40, 4);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode = 2'd2;
    seed = 8'h99;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("restart", 3);
    check("restart_count", 32'(vec_count), 32'd4);

    // async reset mid-run after two accepts
    start_run(2'd1, 8'h20, 10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_rst_count", 32'(vec_count), 32'd2);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(vec_count), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // stop mid-run after three accepts
    start_run(2'd1, 8'h30, 10);
    repeat (3) @(posedge clk);
    #1;
    stop = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    stop = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("stop_valid", 32'(out_valid), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_count", 32'(vec_count), 32'd3);
    check("stop_data", 32'(out_data), 32'h6333);
    check("stop_no_done", 32'(done_cnt), 32'(d0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
